// File: rtl/ac_upsp_collector_if.sv
// PE write lanes plus AXI4-Stream output of the upsampler collector.
// master: collector side (accepts lanes, drives the stream); slave: PE array / DMA side.
interface ac_upsp_collector_if #(
  parameter int N_PARALLEL         = 4,
  parameter int UPSP_WRTDATA_WIDTH = 96
);
  logic [N_PARALLEL-1:0]                    upsp_ac_wvalid;
  logic [N_PARALLEL*UPSP_WRTDATA_WIDTH-1:0] upsp_ac_wdata;
  logic [N_PARALLEL-1:0]                    ac_upsp_wready;
  logic                                     m_axis_tvalid;
  logic [UPSP_WRTDATA_WIDTH-1:0]            m_axis_tdata;
  logic                                     m_axis_tlast;
  logic                                     m_axis_tuser;
  logic                                     m_axis_tready;

  modport master (
    input  upsp_ac_wvalid, upsp_ac_wdata, m_axis_tready,
    output ac_upsp_wready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser
  );

  modport slave (
    output upsp_ac_wvalid, upsp_ac_wdata, m_axis_tready,
    input  ac_upsp_wready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser
  );
endinterface

// File: rtl/ac_upsp_collector.sv
// Round-robin merge of N PE write lanes into one AXI4-Stream with line/frame framing.
// Latency: 1 cycle from lane accept to tvalid.
// Backpressure: single output register; lanes see ready only when it is empty or popping.
module ac_upsp_collector #(
  parameter int N_PARALLEL         = 4,
  parameter int UPSP_WRTDATA_WIDTH = 96,
  parameter int LINE_BEATS         = 960,
  parameter int FRAME_LINES        = 2160,
  parameter int CRF_DATA_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      crf_ac_UPSTART,
  ac_upsp_collector_if.master       bus,
  output logic                      ac_crf_done,
  output logic                      ac_crf_busy,
  output logic [CRF_DATA_WIDTH-1:0] ac_crf_beatcnt
);
  localparam int LANE_W = (N_PARALLEL > 1) ? $clog2(N_PARALLEL) : 1;
  localparam int COL_W  = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam int ROW_W  = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(N_PARALLEL - 1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(LINE_BEATS - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(FRAME_LINES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                        state;
  logic [LANE_W-1:0]             lane_sel;
  logic [COL_W-1:0]              col;
  logic [ROW_W-1:0]              row;
  logic                          out_full;
  logic [UPSP_WRTDATA_WIDTH-1:0] out_dat;
  logic                          out_last;
  logic                          out_user;

  logic                          pop;
  logic                          can_load;
  logic                          accept;
  logic [UPSP_WRTDATA_WIDTH-1:0] sel_dat;

  // Ready depends on tready combinationally so a pop and a load can share a cycle.
  always_comb begin
    pop      = out_full & bus.m_axis_tready;
    can_load = ~out_full | bus.m_axis_tready;
    accept   = (state == RUN) & can_load & bus.upsp_ac_wvalid[lane_sel];
    bus.ac_upsp_wready = '0;
    if ((state == RUN) && can_load) begin
      bus.ac_upsp_wready = N_PARALLEL'(1) << lane_sel;
    end
    sel_dat = '0;
    for (int i = 0; i < N_PARALLEL; i++) begin
      if (lane_sel == LANE_W'(i)) begin
        sel_dat = bus.upsp_ac_wdata[i*UPSP_WRTDATA_WIDTH +: UPSP_WRTDATA_WIDTH];
      end
    end
  end

  assign bus.m_axis_tvalid = out_full;
  assign bus.m_axis_tdata  = out_dat;
  assign bus.m_axis_tlast  = out_last;
  assign bus.m_axis_tuser  = out_user;
  assign ac_crf_busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      lane_sel       <= '0;
      col            <= '0;
      row            <= '0;
      out_full       <= 1'b0;
      out_dat        <= '0;
      out_last       <= 1'b0;
      out_user       <= 1'b0;
      ac_crf_done    <= 1'b0;
      ac_crf_beatcnt <= '0;
    end else begin
      ac_crf_done <= 1'b0;
      if (pop) begin
        ac_crf_beatcnt <= ac_crf_beatcnt + 1'b1;
      end

      if (accept) begin
        out_full <= 1'b1;
        out_dat  <= sel_dat;
        out_user <= (col == '0) && (row == '0);
        out_last <= (col == COL_LAST);
      end else if (pop) begin
        out_full <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (crf_ac_UPSTART) begin
            state          <= RUN;
            lane_sel       <= '0;
            col            <= '0;
            row            <= '0;
            ac_crf_beatcnt <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            lane_sel <= (lane_sel == LANE_LAST) ? '0 : lane_sel + 1'b1;
            if (col == COL_LAST) begin
              col <= '0;
              if (row == ROW_LAST) begin
                row   <= '0;
                state <= DRAIN;
              end else begin
                row <= row + 1'b1;
              end
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        DRAIN: begin
          // No accepts here, so the register holds the final beat; its pop ends the frame.
          if (pop) begin
            ac_crf_done <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ac_upsp_collector.sv
// Scoreboard bench: u0 is N=4/4 beats/2 lines, u1 is N=3/4 beats/1 line.
`timescale 1ns/1ps
module tb_ac_upsp_collector;
  localparam int W = 96;

  typedef struct {
    logic [W-1:0] d;
    logic         l;
    logic         u;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start0 = 1'b0;
  logic start1 = 1'b0;
  logic done0, busy0, done1, busy1;
  logic [31:0] bc0, bc1;

  always #5 clk = ~clk;

  ac_upsp_collector_if #(.N_PARALLEL(4), .UPSP_WRTDATA_WIDTH(W)) bus0 ();
  ac_upsp_collector_if #(.N_PARALLEL(3), .UPSP_WRTDATA_WIDTH(W)) bus1 ();

  ac_upsp_collector #(.N_PARALLEL(4), .UPSP_WRTDATA_WIDTH(W), .LINE_BEATS(4),
                      .FRAME_LINES(2), .CRF_DATA_WIDTH(32)) u0 (
    .clk(clk), .rst_n(rst_n), .crf_ac_UPSTART(start0), .bus(bus0.master),
    .ac_crf_done(done0), .ac_crf_busy(busy0), .ac_crf_beatcnt(bc0));

  ac_upsp_collector #(.N_PARALLEL(3), .UPSP_WRTDATA_WIDTH(W), .LINE_BEATS(4),
                      .FRAME_LINES(1), .CRF_DATA_WIDTH(32)) u1 (
    .clk(clk), .rst_n(rst_n), .crf_ac_UPSTART(start1), .bus(bus1.master),
    .ac_crf_done(done1), .ac_crf_busy(busy1), .ac_crf_beatcnt(bc1));

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int tag = 0;
  beat_t q0[$];
  beat_t q1[$];
  logic [3:0] en0 = '0;
  logic [2:0] en1 = '0;
  int seq0[4];
  int seq1[3];
  logic [3:0] take0 = '0;
  logic [2:0] take1 = '0;
  logic tog0 = 1'b0;
  int hs0 = 0, hs1 = 0, done_cnt0 = 0, done_cnt1 = 0, first0 = 0, last0 = 0;

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(int t, int l, int s);
    return {32'(t), 32'(l), 32'(s)};
  endfunction

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      bus0.upsp_ac_wvalid[i] = en0[i];
      bus0.upsp_ac_wdata[i*W +: W] = mk(tag, i, seq0[i]);
    end
    for (int i = 0; i < 3; i++) begin
      bus1.upsp_ac_wvalid[i] = en1[i];
      bus1.upsp_ac_wdata[i*W +: W] = mk(tag, i, seq1[i]);
    end
  endtask

  // Lane sources: advance a lane's sequence number after each beat it hands over.
  always @(negedge clk) begin
    take0 = bus0.upsp_ac_wvalid & bus0.ac_upsp_wready;
    take1 = bus1.upsp_ac_wvalid & bus1.ac_upsp_wready;
  end

  always @(posedge clk) begin
    cyc++;
    #1;
    for (int i = 0; i < 4; i++) if (take0[i]) seq0[i]++;
    for (int i = 0; i < 3; i++) if (take1[i]) seq1[i]++;
    take0 = '0;
    take1 = '0;
    if (tog0) bus0.m_axis_tready = ~bus0.m_axis_tready;
    drive();
  end

  // Monitor: pops the scoreboard on every output handshake.
  always @(negedge clk) begin
    beat_t b;
    if (rst_n) begin
      if (bus0.m_axis_tvalid) begin
        if (q0.size() == 0) begin
          check("u0 beat with empty queue", 128'(q0.size()), 128'd1);
        end else if (bus0.m_axis_tready) begin
          b = q0.pop_front();
          check("u0 tdata", bus0.m_axis_tdata, b.d);
          check("u0 tlast", bus0.m_axis_tlast, b.l);
          check("u0 tuser", bus0.m_axis_tuser, b.u);
          hs0++;
          if (hs0 == 1) first0 = cyc;
          last0 = cyc;
        end else begin
          check("u0 stalled tdata", bus0.m_axis_tdata, q0[0].d);
        end
      end
      if (done0) begin
        done_cnt0++;
        check("u0 done after 8 beats", 128'(hs0), 128'd8);
        check("u0 queue empty at done", 128'(q0.size()), 128'd0);
      end
      if (bus1.m_axis_tvalid && bus1.m_axis_tready) begin
        if (q1.size() == 0) begin
          check("u1 beat with empty queue", 128'(q1.size()), 128'd1);
        end else begin
          b = q1.pop_front();
          check("u1 tdata", bus1.m_axis_tdata, b.d);
          check("u1 tlast", bus1.m_axis_tlast, b.l);
          check("u1 tuser", bus1.m_axis_tuser, b.u);
          hs1++;
        end
      end
      if (done1) begin
        done_cnt1++;
        check("u1 done after 4 beats", 128'(hs1), 128'd4);
      end
    end
  end

  task automatic cycles(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic new_frame0(int t, int nbeats);
    tag = t;
    hs0 = 0;
    for (int i = 0; i < 4; i++) seq0[i] = 0;
    for (int i = 0; i < nbeats; i++) q0.push_back('{mk(t, i % 4, i / 4), (i % 4) == 3, i == 0});
    drive();
  endtask

  task automatic pulse_start0();
    start0 = 1'b1;
    cycles(1);
    start0 = 1'b0;
  endtask

  task automatic wait_done0(int budget);
    int c0 = done_cnt0;
    int n = 0;
    while (done_cnt0 == c0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #2;
    check("u0 done pulse seen", 128'(done_cnt0 - c0), 128'd1);
  endtask

  initial begin
    int dsave;
    bus0.m_axis_tready = 1'b0;
    bus1.m_axis_tready = 1'b0;
    for (int i = 0; i < 4; i++) seq0[i] = 0;
    for (int i = 0; i < 3; i++) seq1[i] = 0;
    drive();
    #22;
    check("reset tvalid", bus0.m_axis_tvalid, 1'b0);
    check("reset wready", bus0.ac_upsp_wready, 4'h0);
    check("reset busy", busy0, 1'b0);
    check("reset done", done0, 1'b0);
    check("reset beatcnt", bc0, 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    cycles(2);

    // 1: full throughput, all lanes valid
    new_frame0(1, 8);
    en0 = 4'hF; bus0.m_axis_tready = 1'b1; drive();
    pulse_start0();
    check("t1 busy after start", busy0, 1'b1);
    wait_done0(50);
    check("t1 consecutive beats", 128'(last0 - first0), 128'd7);
    check("t1 beatcnt", bc0, 32'd8);
    check("t1 busy after done", busy0, 1'b0);

    // 2: lane 2 held low, nothing taken out of order
    new_frame0(2, 8);
    en0 = 4'b1011; drive();
    pulse_start0();
    for (int i = 0; i < 5; i++) begin
      check("t2 lane3 not ready", bus0.ac_upsp_wready[3], 1'b0);
      cycles(1);
    end
    check("t2 stalled after lane1", 128'(hs0), 128'd2);
    en0 = 4'hF; drive();
    wait_done0(50);
    check("t2 beatcnt", bc0, 32'd8);

    // 3: tready toggling every cycle
    new_frame0(3, 8);
    tog0 = 1'b1;
    pulse_start0();
    wait_done0(100);
    tog0 = 1'b0; bus0.m_axis_tready = 1'b1;
    check("t3 beatcnt", bc0, 32'd8);

    // 4: UPSTART mid-frame ignored, then restart clears beatcnt
    new_frame0(4, 8);
    en0 = 4'b0011; drive();
    pulse_start0();
    cycles(6);
    check("t4 beatcnt before restart", bc0, 32'd2);
    pulse_start0();
    cycles(2);
    check("t4 beatcnt after ignored start", bc0, 32'd2);
    check("t4 busy after ignored start", busy0, 1'b1);
    en0 = 4'hF; drive();
    wait_done0(50);
    check("t4 beatcnt", bc0, 32'd8);
    new_frame0(5, 8);
    pulse_start0();
    check("t4 beatcnt cleared", bc0, 32'd0);
    wait_done0(50);
    check("t4 second beatcnt", bc0, 32'd8);

    // 5: reset with a held beat
    new_frame0(6, 4);
    en0 = 4'b0111; drive();
    pulse_start0();
    cycles(6);
    check("t5 three beats out", 128'(hs0), 128'd3);
    bus0.m_axis_tready = 1'b0; en0 = 4'hF; drive();
    cycles(3);
    check("t5 held tvalid", bus0.m_axis_tvalid, 1'b1);
    check("t5 held tdata", bus0.m_axis_tdata, mk(6, 3, 0));
    dsave = done_cnt0;
    #1 rst_n = 1'b0;
    #1;
    check("t5 tvalid in reset", bus0.m_axis_tvalid, 1'b0);
    check("t5 wready in reset", bus0.ac_upsp_wready, 4'h0);
    check("t5 busy in reset", busy0, 1'b0);
    q0.delete();
    cycles(2);
    check("t5 no done on reset", 128'(done_cnt0), 128'(dsave));
    rst_n = 1'b1;
    bus0.m_axis_tready = 1'b1;
    cycles(1);
    new_frame0(7, 8);
    pulse_start0();
    wait_done0(50);
    check("t5 fresh frame beatcnt", bc0, 32'd8);

    // 6: three lanes, one line
    tag = 8; hs1 = 0;
    for (int i = 0; i < 3; i++) seq1[i] = 0;
    for (int i = 0; i < 4; i++) q1.push_back('{mk(8, i % 3, i / 3), i == 3, i == 0});
    en1 = 3'b111; bus1.m_axis_tready = 1'b1; drive();
    dsave = done_cnt1;
    start1 = 1'b1;
    cycles(1);
    start1 = 1'b0;
    for (int n = 0; n < 50 && done_cnt1 == dsave; n++) cycles(1);
    check("t6 done pulse seen", 128'(done_cnt1 - dsave), 128'd1);
    check("t6 beatcnt", bc1, 32'd4);
    check("t6 queue drained", 128'(q1.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
